trivium_stream_xor: RTL and testbench
=====================================

# trivium_stream_xor

Downstream stage for the Trivium keystream generator. It drives the generator's `enable`, captures the keystream bytes it produces into a small prefetch FIFO, and XORs them one-for-one with a byte stream arriving on a valid/ready input. The result goes out on a registered valid/ready output, so the same block encrypts and decrypts. It can also discard a fixed number of leading keystream bytes before using any of them.

## Interface
- `FIFO_DEPTH`, default 4: keystream prefetch depth. Must be a power of two and at least 2.
- `DISCARD`, default 0: number of keystream bytes dropped after reset before any byte is stored. Range 0..65535.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high. Clears all state. Must also be applied to the generator so the two stay aligned.
- `ks_enable` out 1: registered enable to the generator. Each cycle it is high requests one keystream byte.
- `ks_byte` in 8: generator keystream output.
- `in_valid` in 1, `in_ready` out 1, `in_data` in 8, `in_last` in 1: input byte stream (plaintext or ciphertext).
- `out_valid` out 1, `out_ready` in 1, `out_data` out 8, `out_last` out 1: output byte stream.
- `byte_count` out 16: count of bytes accepted on the input since reset.
- `busy` out 1: high while `out_valid` is high or the discard phase is not complete.

## Operation
- **Generator contract:** when `ks_enable` is high in cycle t, `ks_byte` holds the new byte throughout cycle t+1. The block samples it at the edge ending cycle t+1.
- **Prefetch flow control:**
  - `ks_enable` is a register.
  - Invariant: FIFO occupancy plus bytes in flight never exceeds `FIFO_DEPTH`. A byte is in flight when `ks_enable` was high in the previous cycle.
  - `ks_enable` is set for the next cycle only if that invariant still holds after the next cycle's push and pop.
  - Steady state with a continuously ready output: one keystream byte per cycle.
- **Discard phase:**
  - A 16-bit `discard_cnt` counts received keystream bytes.
  - While `discard_cnt < DISCARD`, received bytes are dropped, not pushed.
  - Requests continue at full rate during this phase.
  - With `DISCARD=0` there is no discard phase.
- **FIFO:**
  - Circular buffer with read and write pointers of log2(`FIFO_DEPTH`)+1 bits, wrapping at the power-of-two boundary.
  - Full when the MSBs differ and the low bits are equal. Empty when the pointers are equal.
  - Simultaneous push and pop leaves occupancy unchanged. This is legal even when the FIFO is full.
  - A push never occurs while full; the invariant guarantees this.
- **Datapath:**
  - `in_ready = !fifo_empty && (!out_valid || out_ready)`.
  - On an input handshake:
    - `out_data <= in_data ^ fifo_head`
    - `out_last <= in_last`
    - `out_valid <= 1`
    - pop the FIFO
    - `byte_count <= byte_count + 1`, wrapping 0xFFFF to 0x0000.
  - On an output handshake with no input handshake in the same cycle, `out_valid <= 0`.
  - `out_data` and `out_last` hold while `out_valid && !out_ready`.
- **`in_last`:** carried only to `out_last`. It does not reset the keystream or `byte_count`. Keystream is continuous across frames.
- **Reset mid-operation:** FIFO contents, pointers, `discard_cnt` and the output register are cleared immediately. Any in-flight keystream byte is lost; the generator must be reset with it.

## Timing
- **Reset values:** `ks_enable=0`, `in_ready=0`, `out_valid=0`, `out_data=0x00`, `out_last=0`, `byte_count=0x0000`. `busy` is 1 if `DISCARD>0`, else 0.
- **Startup** (edge E0 is the first edge with `rst` low, `DISCARD=0`):
  - `ks_enable` goes high after E0.
  - First byte pushed at E2.
  - `in_ready` high from E2.
- **Throughput:**
  - Input to output latency: 1 cycle (registered output).
  - Full throughput: one byte per cycle with `out_ready` held high.
- **Backpressure:**
  - `out_ready` low with `out_valid` high forces `in_ready` low in the same cycle.
  - The FIFO fills to `FIFO_DEPTH` and `ks_enable` drops.
  - When the FIFO drains, `ks_enable` re-asserts within 1 cycle of space appearing.
- **Discard:** takes `DISCARD` requested bytes. `in_ready` first rises at E(2+`DISCARD`) when the output is idle.

## Test plan
Every scenario uses a bench generator model: `ks_byte` starts at 0x00 and increments by 1 on each cycle `ks_enable` is high, so the k-th requested byte is k, starting at 1.
- **Startup and streaming:** reset, `DISCARD=0`, stream `in_data` 0x10,0x20,0x30 with `out_ready=1` -> `out_data` 0x11,0x22,0x33; `in_ready` first high at E2; `byte_count=3`.
- **Discard:** `DISCARD=3`, send 0x00 -> `out_data=0x04`; no `in_ready` before E5.
- **Backpressure:** `out_ready=0` for 10 cycles while `in_valid=1` -> exactly one byte accepted; `out_data` held; FIFO holds `FIFO_DEPTH` bytes; `ks_enable` low. Release -> bytes continue as 0x02,0x03,... with no keystream byte skipped or repeated.
- **Full-rate push/pop at full FIFO:** 64 back-to-back bytes with `out_ready=1` -> 64 outputs on consecutive cycles; `out_data` always equals `in_data ^ k`; `in_last` on byte 64 appears on `out_last` only.
- **Counter wrap:** 65537 bytes -> `byte_count=0x0001`.
- **Reset mid-stream:** assert `rst` during streaming with `out_valid=1` -> all outputs return to their reset values asynchronously. After release with the generator also reset, the first output is `in_data ^ 0x01`.

Source files
------------

// File: rtl/trivium_stream_xor.sv
// -----------------------------------------------------------------------------
// trivium_stream_xor
//
// Downstream stage for a Trivium keystream generator. Requests keystream bytes
// from the generator, keeps them in a small prefetch FIFO and XORs them
// one-for-one with an incoming byte stream. Because XOR is its own inverse the
// same block encrypts and decrypts. Optionally throws away the first DISCARD
// keystream bytes after reset before any of them is used.
//
// Parameters
//   FIFO_DEPTH : keystream prefetch depth, power of two, >= 2
//   DISCARD    : leading keystream bytes dropped after reset (0..65535)
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset; the generator must share it
//   ks_enable  : registered request to the generator, one byte per high cycle
//   ks_byte    : generator output, valid the cycle after ks_enable was high
//   in_valid / in_ready / in_data / in_last     : input byte stream
//   out_valid / out_ready / out_data / out_last : registered output stream
//   byte_count : input bytes accepted since reset, wraps at 16 bits
//   busy       : output register holds data, or the discard phase is running
//
// Handshake semantics (both streams): a transfer happens on a rising edge
// where valid and ready are both high. A producer holding valid high keeps its
// data and last stable until that transfer; ready may depend combinationally
// on the receiver's own state but never on the producer's valid.
// -----------------------------------------------------------------------------
module trivium_stream_xor #(
  parameter int FIFO_DEPTH = 4,
  parameter int DISCARD    = 0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ks_enable,
  input  logic [7:0]  ks_byte,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic [15:0] byte_count,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  // Occupancy arithmetic uses one extra bit so push/pop/in-flight sums
  // cannot overflow before the comparison against the depth.
  localparam logic [AW+1:0] DEPTH_W   = (AW+2)'(FIFO_DEPTH);
  localparam logic          DISC_NONE = (DISCARD == 0);
  // Value of discard_cnt when the final byte to drop arrives. Unused when
  // DISCARD is zero because discard_done then starts out set.
  localparam logic [15:0]   DISC_LAST = 16'(DISCARD - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          ks_pending;    // ks_enable delayed: ks_byte is valid this cycle
  logic [15:0]   discard_cnt;
  logic          discard_done;

  // ---------------------------------------------------------------------------
  // FIFO status and handshake decode
  // ---------------------------------------------------------------------------
  logic          fifo_empty;
  logic          fifo_full;
  logic [7:0]    fifo_head;
  logic          push;
  logic          pop;
  logic          in_hs;
  logic          out_hs;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fifo_head  = mem[rd_ptr[AW-1:0]];

  assign in_ready = !fifo_empty && (!out_valid || out_ready);
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;

  // The request throttle already keeps a push away from a full FIFO; the
  // full term only stops a corrupted write if that ever went wrong.
  assign push = ks_pending && discard_done && !fifo_full;
  assign pop  = in_hs;

  assign busy = out_valid || !discard_done;

  // ---------------------------------------------------------------------------
  // Request throttle
  //
  // Every requested byte is either stored, in flight, or about to be
  // requested. After this edge the FIFO holds occ_next bytes and the byte
  // requested this cycle (ks_enable) is still in flight. A further request is
  // issued only if all of those plus the new one still fit in the FIFO.
  // Discarded bytes are never pushed, so during the discard phase the FIFO
  // stays empty and requests run at full rate.
  // ---------------------------------------------------------------------------
  logic [AW:0]   occ;
  logic [AW+1:0] occ_next;
  logic [AW+1:0] committed;
  logic          ks_enable_next;

  always_comb begin
    occ            = wr_ptr - rd_ptr;
    occ_next       = {1'b0, occ} + (AW+2)'(push) - (AW+2)'(pop);
    committed      = occ_next + (AW+2)'(ks_enable);
    ks_enable_next = (committed < DEPTH_W);
  end

  // ---------------------------------------------------------------------------
  // Control and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ks_enable    <= 1'b0;
      ks_pending   <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      discard_cnt  <= 16'h0000;
      discard_done <= DISC_NONE;
      out_valid    <= 1'b0;
      out_data     <= 8'h00;
      out_last     <= 1'b0;
      byte_count   <= 16'h0000;
    end else begin
      ks_enable  <= ks_enable_next;
      ks_pending <= ks_enable;

      if (ks_pending && !discard_done) begin
        discard_cnt <= discard_cnt + 16'd1;
        if (discard_cnt == DISC_LAST) begin
          discard_done <= 1'b1;
        end
      end

      if (push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end

      if (in_hs) begin
        out_data   <= in_data ^ fifo_head;
        out_last   <= in_last;
        out_valid  <= 1'b1;
        byte_count <= byte_count + 16'd1;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Keystream storage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (push) begin
      mem[wr_ptr[AW-1:0]] <= ks_byte;
    end
  end

endmodule

// File: tb/tb_trivium_stream_xor.sv
module tb_trivium_stream_xor;

  localparam int DEPTH = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance, DISCARD = 0
  logic        ks_enable;
  logic [7:0]  ks_byte;
  logic        in_valid, in_ready, in_last;
  logic [7:0]  in_data;
  logic        out_valid, out_ready, out_last;
  logic [7:0]  out_data;
  logic [15:0] byte_count;
  logic        busy;

  // Second instance, DISCARD = 3
  logic        ks_enable2;
  logic [7:0]  ks_byte2;
  logic        in_valid2, in_ready2, in_last2;
  logic [7:0]  in_data2;
  logic        out_valid2, out_ready2, out_last2;
  logic [7:0]  out_data2;
  logic [15:0] byte_count2;
  logic        busy2;

  trivium_stream_xor #(.FIFO_DEPTH(DEPTH), .DISCARD(0)) dut (
    .clk(clk), .rst(rst), .ks_enable(ks_enable), .ks_byte(ks_byte),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .byte_count(byte_count), .busy(busy)
  );

  trivium_stream_xor #(.FIFO_DEPTH(DEPTH), .DISCARD(3)) dut_d3 (
    .clk(clk), .rst(rst), .ks_enable(ks_enable2), .ks_byte(ks_byte2),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2), .in_last(in_last2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_last(out_last2),
    .byte_count(byte_count2), .busy(busy2)
  );

  // Generator models: k-th requested byte is k.
  always @(posedge clk or posedge rst) begin
    if (rst) ks_byte <= 8'h00;
    else if (ks_enable) ks_byte <= ks_byte + 8'd1;
  end
  always @(posedge clk or posedge rst) begin
    if (rst) ks_byte2 <= 8'h00;
    else if (ks_enable2) ks_byte2 <= ks_byte2 + 8'd1;
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] actual,
                          input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard: {last, data} pushed on input handshake, popped on output.
  // ks_exp is the keystream byte the next accepted input must use.
  // ---------------------------------------------------------------------------
  logic [8:0] exp_q[$];
  logic [8:0] exp_v;
  logic [7:0] ks_exp   = 8'd1;
  int         acc_cnt  = 0;
  int         last_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        check_eq("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_v = exp_q.pop_front();
          check_eq("out_byte", 32'({out_last, out_data}), 32'(exp_v));
        end
        if (out_last) last_cnt++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({in_last, in_data ^ ks_exp});
        ks_exp = ks_exp + 8'd1;
        acc_cnt++;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic send_byte(input logic [7:0] d, input logic l, output int cycles);
    logic hs;
    hs = 1'b0;
    cycles = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!hs && cycles < 100) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      cycles++;
    end
    check_eq("in_accept", 32'(hs), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    in_valid  = 1'b0;
    in_valid2 = 1'b0;
    in_last   = 1'b0;
    exp_q.delete();
    ks_exp = 8'd1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int n;
  int stall;
  int base;

  initial begin
    rst = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b1;
    in_valid2 = 1'b0; in_data2 = 8'h00; in_last2 = 1'b0; out_ready2 = 1'b1;
    #1 rst = 1'b1;
    #20;

    // Reset values
    check_eq("rst_ks_enable", 32'(ks_enable), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'h00);
    check_eq("rst_out_last", 32'(out_last), 32'd0);
    check_eq("rst_byte_count", 32'(byte_count), 32'h0000);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_busy_d3", 32'(busy2), 32'd1);
    check_eq("rst_in_ready_d3", 32'(in_ready2), 32'd0);

    // Startup: release 2 units after an edge, so the next edge is E0
    @(posedge clk); #2; rst = 1'b0;
    @(posedge clk); #1;                                   // E0
    check_eq("e0_ks_enable", 32'(ks_enable), 32'd1);
    check_eq("e0_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;                                   // E1
    check_eq("e1_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;                                   // E2
    check_eq("e2_in_ready", 32'(in_ready), 32'd1);
    check_eq("e2_in_ready_d3", 32'(in_ready2), 32'd0);
    @(posedge clk); #1;                                   // E3
    check_eq("e3_busy_d3", 32'(busy2), 32'd1);
    @(posedge clk); #1;                                   // E4
    check_eq("e4_in_ready_d3", 32'(in_ready2), 32'd0);
    @(posedge clk); #1;                                   // E5
    check_eq("e5_in_ready_d3", 32'(in_ready2), 32'd1);
    check_eq("e5_busy_d3", 32'(busy2), 32'd0);

    // Discard instance: 0x00 ^ fourth keystream byte
    in_valid2 = 1'b1; in_data2 = 8'h00;
    @(negedge clk);
    check_eq("d3_ready", 32'(in_ready2), 32'd1);
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    check_eq("d3_out_valid", 32'(out_valid2), 32'd1);
    check_eq("d3_out_data", 32'(out_data2), 32'h04);
    check_eq("d3_byte_count", 32'(byte_count2), 32'd1);

    // Startup streaming 0x10,0x20,0x30 -> 0x11,0x22,0x33
    out_ready = 1'b1;
    send_byte(8'h10, 1'b0, n);
    check_eq("s1_data", 32'(out_data), 32'h11);
    send_byte(8'h20, 1'b0, n);
    check_eq("s2_data", 32'(out_data), 32'h22);
    send_byte(8'h30, 1'b0, n);
    check_eq("s3_data", 32'(out_data), 32'h33);
    in_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    check_eq("s_byte_count", 32'(byte_count), 32'd3);
    check_eq("s_out_idle", 32'(out_valid), 32'd0);

    // Backpressure: out_ready low for 10 cycles with input offered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'($urandom_range(0, 255));
    base = acc_cnt;
    repeat (10) @(posedge clk);
    #1;
    check_eq("bp_accepted", 32'(acc_cnt - base), 32'd1);
    check_eq("bp_out_valid", 32'(out_valid), 32'd1);
    check_eq("bp_out_held", 32'(out_data), 32'(exp_q[0][7:0]));
    check_eq("bp_in_ready", 32'(in_ready), 32'd0);
    check_eq("bp_ks_enable", 32'(ks_enable), 32'd0);
    check_eq("bp_fifo_level", 32'(8'(ks_byte - ks_exp + 8'd1)), 32'(DEPTH));
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) send_byte(8'($urandom_range(0, 255)), 1'b0, n);
    in_valid = 1'b0;
    repeat (4) @(posedge clk); #1;

    // 64 back-to-back bytes, last flag on the final one only
    base = last_cnt;
    stall = 0;
    for (int i = 1; i <= 64; i++) begin
      send_byte(8'($urandom_range(0, 255)), (i == 64), n);
      stall += n - 1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    repeat (3) @(posedge clk); #1;
    check_eq("burst_stalls", 32'(stall), 32'd0);
    check_eq("burst_last_cnt", 32'(last_cnt - base), 32'd1);

    // Reset mid-stream with out_valid high
    send_byte(8'h77, 1'b0, n);
    in_valid = 1'b0;
    check_eq("mr_out_valid_pre", 32'(out_valid), 32'd1);
    #1;
    rst = 1'b1;
    exp_q.delete();
    ks_exp = 8'd1;
    #1;
    check_eq("mr_out_valid", 32'(out_valid), 32'd0);
    check_eq("mr_out_data", 32'(out_data), 32'h00);
    check_eq("mr_out_last", 32'(out_last), 32'd0);
    check_eq("mr_in_ready", 32'(in_ready), 32'd0);
    check_eq("mr_ks_enable", 32'(ks_enable), 32'd0);
    check_eq("mr_byte_count", 32'(byte_count), 32'h0000);
    check_eq("mr_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #2; rst = 1'b0;
    send_byte(8'h5A, 1'b0, n);
    in_valid = 1'b0;
    check_eq("mr_first_out", 32'(out_data), 32'h5B);
    repeat (3) @(posedge clk); #1;

    // Counter wrap: 65537 bytes after a fresh reset
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 65537; i++) send_byte(8'($urandom_range(0, 255)), 1'b0, n);
    in_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    check_eq("wrap_byte_count", 32'(byte_count), 32'h0001);

    repeat (3) @(posedge clk); #1;
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
